// File: rtl/adpll_mode_ctrl.sv
// ADPLL acquisition mode controller.
// Walks the DCO through PVT -> ACQ -> TRK banks as the phase error settles,
// drops back to PVT on loss of lock, and flags attempts that run too long.
module adpll_mode_ctrl #(
  parameter int PHE_W   = 12,
  parameter int THR_PVT = 64,
  parameter int THR_ACQ = 8,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [PHE_W-1:0] phe,
  input  logic             phe_vld,
  output logic [1:0]       mode,
  output logic             pvt_en,
  output logic             acq_en,
  output logic             trk_en,
  output logic             lock,
  output logic             timeout_err
);

  localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]    SETTLE_M1 = CW'(SETTLE - 1);
  localparam logic [CW-1:0]    TMO_C     = CW'(TIMEOUT);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [PHE_W:0]   THR_PVT_C = (PHE_W + 1)'(THR_PVT);
  localparam logic [PHE_W:0]   THR_ACQ_C = (PHE_W + 1)'(THR_ACQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PVT  = 2'b01,
    S_ACQ  = 2'b10,
    S_TRK  = 2'b11
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_settle, w_settle_nxt;
  logic [CW-1:0] r_tmo, w_tmo_nxt, w_tmo_inc;
  logic          r_err, w_err_nxt;
  logic          r_pvt_en, r_acq_en, r_trk_en, r_lock;
  logic          w_pvt_en_nxt, w_acq_en_nxt, w_trk_en_nxt, w_lock_nxt;

  // Magnitude is formed one bit wider so the most negative code does not wrap
  logic [PHE_W:0] w_phe_ext, w_phe_abs;
  logic           w_in_pvt, w_in_acq, w_in_cur;

  assign w_phe_ext = {phe[PHE_W-1], phe};
  assign w_phe_abs = phe[PHE_W-1] ? (~w_phe_ext + (PHE_W + 1)'(1)) : w_phe_ext;
  assign w_in_pvt  = (w_phe_abs < THR_PVT_C);
  assign w_in_acq  = (w_phe_abs < THR_ACQ_C);
  assign w_in_cur  = (r_state == S_ACQ) ? w_in_acq : w_in_pvt;
  assign w_tmo_inc = (r_tmo == TMO_C) ? r_tmo : (r_tmo + CNT_ONE);

  // State, counter and registered-output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
      r_tmo    <= '0;
      r_err    <= 1'b0;
      r_pvt_en <= 1'b0;
      r_acq_en <= 1'b0;
      r_trk_en <= 1'b0;
      r_lock   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
      r_tmo    <= w_tmo_nxt;
      r_err    <= w_err_nxt;
      r_pvt_en <= w_pvt_en_nxt;
      r_acq_en <= w_acq_en_nxt;
      r_trk_en <= w_trk_en_nxt;
      r_lock   <= w_lock_nxt;
    end
  end

  // Next-state and counter logic; en low overrides every sample event
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    w_tmo_nxt    = r_tmo;
    w_err_nxt    = r_err;
    if (!en) begin
      w_state_nxt  = S_IDLE;
      w_settle_nxt = '0;
      w_tmo_nxt    = '0;
      w_err_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt  = S_PVT;
          w_settle_nxt = '0;
          w_tmo_nxt    = '0;
        end
        S_PVT, S_ACQ: begin
          if (phe_vld) begin
            // Timeout only raises the flag; settling keeps being evaluated
            w_tmo_nxt = w_tmo_inc;
            if (w_tmo_inc == TMO_C) w_err_nxt = 1'b1;
            if (w_in_cur) begin
              if (r_settle == SETTLE_M1) begin
                w_state_nxt  = (r_state == S_PVT) ? S_ACQ : S_TRK;
                w_settle_nxt = '0;
                w_tmo_nxt    = '0;
              end else begin
                w_settle_nxt = r_settle + CNT_ONE;
              end
            end else begin
              w_settle_nxt = '0;
            end
          end
        end
        S_TRK: begin
          if (phe_vld) begin
            if (!w_in_pvt) begin
              if (r_settle == SETTLE_M1) begin
                w_state_nxt  = S_PVT;
                w_settle_nxt = '0;
                w_tmo_nxt    = '0;
              end else begin
                w_settle_nxt = r_settle + CNT_ONE;
              end
            end else begin
              w_settle_nxt = '0;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state so outputs register alongside mode
  always_comb begin
    w_pvt_en_nxt = (w_state_nxt == S_PVT);
    w_acq_en_nxt = (w_state_nxt == S_ACQ);
    w_trk_en_nxt = (w_state_nxt == S_TRK);
    w_lock_nxt   = (w_state_nxt == S_TRK);
  end

  assign mode        = r_state;
  assign pvt_en      = r_pvt_en;
  assign acq_en      = r_acq_en;
  assign trk_en      = r_trk_en;
  assign lock        = r_lock;
  assign timeout_err = r_err;

endmodule

// File: tb/tb_adpll_mode_ctrl.sv
// Directed bench for adpll_mode_ctrl with default parameters.
module tb_adpll_mode_ctrl;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] phe;
  logic        phe_vld;
  logic [1:0]  mode;
  logic        pvt_en, acq_en, trk_en, lock, timeout_err;

  int n_pass  = 0;
  int n_total = 0;

  adpll_mode_ctrl #(
    .PHE_W(12), .THR_PVT(64), .THR_ACQ(8), .SETTLE(16), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .phe(phe), .phe_vld(phe_vld),
    .mode(mode), .pvt_en(pvt_en), .acq_en(acq_en), .trk_en(trk_en),
    .lock(lock), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: drive on the falling edge, settle 1 time unit past the rising edge
  task automatic step(input int v, input int p);
    @(negedge clk);
    phe_vld = 1'(v);
    phe     = 12'(p);
    @(posedge clk);
    #1;
    phe_vld = 1'b0;
  endtask

  // Expected enables/lock are decoded from the expected mode
  task automatic chk(input string tag, input int em, input int el, input int ee);
    logic [6:0] obs, exp;
    obs = {mode, pvt_en, acq_en, trk_en, lock, timeout_err};
    exp = {2'(em), (em == 1), (em == 2), (em == 3), 1'(el), 1'(ee)};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s obs(mode,pvt,acq,trk,lock,err)=%b exp=%b", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; phe = '0; phe_vld = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk("reset_async", 0, 0, 0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    chk("idle_to_pvt", 1, 0, 0);

    // Normal acquisition: PVT -> ACQ -> TRK
    for (int i = 0; i < 15; i++) begin step(1, 10); chk("pvt_settling", 1, 0, 0); end
    step(1, 10);  chk("pvt_to_acq", 2, 0, 0);
    for (int i = 0; i < 15; i++) begin step(1, -3); chk("acq_settling", 2, 0, 0); end
    step(1, -3);  chk("acq_to_trk", 3, 1, 0);
    for (int i = 0; i < 3; i++) begin step(0, 2000); chk("trk_hold_novld", 3, 1, 0); end

    // Loss of lock requires SETTLE consecutive out samples
    for (int i = 0; i < 15; i++) step(1, -100);
    chk("trk_15_out", 3, 1, 0);
    step(1, 0);   chk("trk_in_clears", 3, 1, 0);
    for (int i = 0; i < 15; i++) step(1, -100);
    chk("trk_15_out_again", 3, 1, 0);
    step(1, -100); chk("trk_lost_lock", 1, 0, 0);

    // Boundary 64 is out in PVT and restarts the settle count
    for (int i = 0; i < 15; i++) step(1, 5);
    step(1, 64);  chk("pvt_64_is_out", 1, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 5);
    chk("pvt_15_after_restart", 1, 0, 0);
    step(1, 5);   chk("pvt_advance_after_16", 2, 0, 0);

    // ACQ: 8 and -2048 are both out
    for (int i = 0; i < 15; i++) step(1, -3);
    step(1, 8);   chk("acq_8_is_out", 2, 0, 0);
    for (int i = 0; i < 15; i++) step(1, -3);
    step(1, -2048); chk("acq_min_no_wrap", 2, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 7);
    chk("acq_15_after_min", 2, 0, 0);

    // Asynchronous reset mid-ACQ
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("reset_mid_acq", 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_pvt", 1, 0, 0);
    step(1, 7);   chk("no_partial_progress", 1, 0, 0);

    // Timeout: flag after TIMEOUT samples, state held, advance still allowed
    for (int i = 0; i < 253; i++) step(1, 500);
    chk("tmo_254_no_err", 1, 0, 0);
    step(1, 500); chk("tmo_255_err", 1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, -500);
    chk("tmo_saturated_hold", 1, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0);
    chk("tmo_advance_keeps_err", 2, 0, 1);
    step(0, 0);   chk("err_sticky", 2, 0, 1);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    chk("en_low_clears", 0, 0, 0);

    // Timeout and settle completion on the same sample
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    chk("reenable_pvt", 1, 0, 0);
    for (int i = 0; i < 239; i++) step(1, 300);
    for (int i = 0; i < 15; i++) step(1, 1);
    chk("coincide_before", 1, 0, 0);
    step(1, 1);   chk("coincide_advance_and_err", 2, 0, 1);

    // en=0 wins over a valid in-threshold sample
    @(negedge clk); en = 1'b0; phe_vld = 1'b1; phe = '0;
    @(posedge clk); #1;
    phe_vld = 1'b0;
    chk("en_priority", 0, 0, 0);
    step(1, 0);   chk("idle_stays_en_low", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard stop so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
